alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//  Multi-cycle successor to the single-cycle ALU. It adds the RV32I shifts and compares plus the RV32M multiply/divide ops.
//  Sits in EX. Simple ops finish in 1 cycle; MUL*/DIV*/REM* run iteratively, one bit per cycle.
//  Uses a valid/ready handshake so the pipeline can stall on long ops. A flush input kills an in-flight op.
// PARAMETERS
//  DATA_WIDTH     32  operand/result width; even, >=8
//  OPCODE_LENGTH  5   Operation width; the codes below need 5 bits
// PORTS
//  clk        in   1              clock; single clock domain
//  reset      in   1              synchronous, active-high
//  in_valid   in   1              SrcA/SrcB/Operation valid this cycle
//  in_ready   out  1              accepts an op when in_valid&&in_ready
//  SrcA       in   DATA_WIDTH     operand A (dividend / multiplicand)
//  SrcB       in   DATA_WIDTH     operand B (divisor / multiplier / shamt)
//  Operation  in   OPCODE_LENGTH  op code, see alu_pkg
//  flush      in   1              abort the current op, drop its result
//  out_valid  out  1              ALUResult holds the result of the accepted op
//  out_ready  in   1              consumer takes the result when out_valid&&out_ready
//  ALUResult  out  DATA_WIDTH     registered result
//  busy       out  1              iterative op in progress
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1, out_valid=0, ALUResult=0, busy=0. All outputs are registered except in_ready.
//  Op codes:
//   - Simple ops: AND 00000, OR 00001, ADD 00010, SUB 00011, XOR 00100, SLL 00101, SRA 00110, SLT 00111,
//     EQ 01000, SRL 01001, SLTU 01010. EQ returns 1/0.
//   - Iterative ops: MUL 10000, MULH 10001, MULHU 10010, DIV 10100, DIVU 10101, REM 10110, REMU 10111.
//   - Any other code: result 0, latency 1.
//  Arithmetic rules:
//   - Shift amount = SrcB[$clog2(DATA_WIDTH)-1:0]. ADD/SUB wrap modulo 2^DATA_WIDTH.
//   - MUL returns the low half of the product; MULH/MULHU return the high half.
//     MULH is signed x signed, MULHU is unsigned x unsigned.
//  FSM IDLE -> {DONE | ITER | DONE} -> IDLE:
//   - IDLE, accept: simple op computes and goes to DONE; out_valid goes high 1 cycle after accept.
//   - IDLE, accept mul/div: latch magnitudes and sign flags, count=DATA_WIDTH, go to ITER.
//   - ITER: one shift-add (mul) or restoring subtract (div) step per cycle, count--.
//     At count==0, apply the sign fix and go to DONE.
//     Result latency = DATA_WIDTH+1 cycles from accept (33 at default).
//   - DONE: hold out_valid and ALUResult stable until out_ready.
//  Handshake:
//   - in_ready = (state==IDLE) || (state==DONE && out_ready). This gives back-to-back issue with no bubble.
//   - When a new op is accepted in the same cycle a result is consumed, the new op is processed next.
//  Division special cases, resolved at accept with latency 1 and no ITER:
//   - divide by zero: DIV/DIVU = all ones; REM/REMU = SrcA.
//   - signed overflow (SrcA=MIN, SrcB=-1): DIV = MIN; REM = 0.
//  Signs:
//   - DIV: quotient is negative iff the operand signs differ.
//   - REM: remainder takes the sign of the dividend.
//  flush:
//   - In any state, go to IDLE next cycle; out_valid=0; an op offered in the same cycle is not accepted.
//   - in_ready is forced to 0 while flush=1.
//   - ALUResult keeps its last value.
//  reset mid-op: same as flush, and ALUResult also returns to 0. reset has priority over flush.
//  Back-pressure: out_valid, once high, must not drop and ALUResult must not change until consumed, unless flush or reset.
// STRUCTURE
//  alu_pkg:
//   - typedef enum logic [4:0] alu_op_e holding the op codes above.
//   - helpers is_muldiv(op) and is_signed_op(op).
//   - typedef enum state_e {IDLE, ITER, DONE}.
//  Sub-module alu_muldiv_iter:
//   - unsigned radix-2 shift-add multiplier / restoring divider core on magnitudes.
//   - ports: start, is_div, a, b, done, hi, lo.
//   - hi/lo = product high/low, or remainder/quotient for divide.
//  alu_mc keeps the simple-op combinational path, the FSM, the handshake, special cases and the sign fix.
// TESTING
//  1. ADD 7FFFFFFF+1; out_ready=1 -> out_valid 1 cycle after accept, ALUResult=80000000; back-to-back XOR with no bubble.
//  2. MUL FFFFFFFF*FFFFFFFF -> 00000001 at cycle 33. Then:
//     - MULH -> 00000000
//     - MULHU -> FFFFFFFE
//     - MULH 80000000*80000000 -> 40000000
//  3. Signed divide:
//     - DIV -7/2 -> FFFFFFFD; REM -7/2 -> FFFFFFFF.
//     - DIV 80000000/FFFFFFFF -> 80000000 at latency 1; REM -> 0.
//  4. Zero divisor: DIVU 5/0 -> FFFFFFFF, REMU 5/0 -> 5, both latency 1, busy never set.
//  5. Back-pressure and flush:
//     - out_ready=0 for 10 cycles after DONE -> out_valid and ALUResult stable, in_ready=0.
//     - flush at ITER cycle 12 -> IDLE next cycle, out_valid stays 0, next op executes correctly.
//  6. Reset mid-DIV: out_valid=0, ALUResult=0, in_ready=1 next cycle.
//     Sweep SLL/SRA/SRL with shamt 0, 31, 32; shamt 32 acts as 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Op codes, FSM states and op-class helpers shared by the multi-cycle ALU.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_AND   = 5'b00000,
    OP_OR    = 5'b00001,
    OP_ADD   = 5'b00010,
    OP_SUB   = 5'b00011,
    OP_XOR   = 5'b00100,
    OP_SLL   = 5'b00101,
    OP_SRA   = 5'b00110,
    OP_SLT   = 5'b00111,
    OP_EQ    = 5'b01000,
    OP_SRL   = 5'b01001,
    OP_SLTU  = 5'b01010,
    OP_MUL   = 5'b10000,
    OP_MULH  = 5'b10001,
    OP_MULHU = 5'b10010,
    OP_DIV   = 5'b10100,
    OP_DIVU  = 5'b10101,
    OP_REM   = 5'b10110,
    OP_REMU  = 5'b10111
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op[4:3] == 2'b10) && (op[2:0] != 3'b011);
  endfunction

  function automatic logic is_signed_op(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return op[4:2] == 3'b101;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Unsigned radix-2 shift-add multiplier / restoring divider on magnitudes.
// First step is taken on the start edge, so done rises DATA_WIDTH-1 cycles after start.
module alu_muldiv_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         is_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);
  import alu_pkg::*;

  localparam int CW = $clog2(W);

  logic [CW-1:0] count;
  logic          div_q;
  logic [W-1:0]  opnd_q;
  logic          mode;
  logic [W-1:0]  opnd, cur_hi, cur_lo, hi_nxt, lo_nxt;
  logic [W:0]    sum, rem_sh, diff;

  // mul: lo holds the multiplier, product shifts in from the top.
  // div: lo holds the dividend, quotient bits shift in from the bottom.
  always_comb begin
    mode   = start ? is_div : div_q;
    opnd   = start ? (is_div ? b : a) : opnd_q;
    cur_hi = start ? '0 : hi;
    cur_lo = start ? (is_div ? a : b) : lo;
    sum    = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, opnd} : '0);
    rem_sh = {cur_hi, cur_lo[W-1]};
    diff   = rem_sh - {1'b0, opnd};
    if (mode) begin
      if (diff[W]) begin
        hi_nxt = rem_sh[W-1:0];
        lo_nxt = {cur_lo[W-2:0], 1'b0};
      end else begin
        hi_nxt = diff[W-1:0];
        lo_nxt = {cur_lo[W-2:0], 1'b1};
      end
    end else begin
      hi_nxt = sum[W:1];
      lo_nxt = {sum[0], cur_lo[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
      div_q  <= 1'b0;
      opnd_q <= '0;
    end else if (start) begin
      count  <= CW'(W - 1);
      hi     <= hi_nxt;
      lo     <= lo_nxt;
      div_q  <= is_div;
      opnd_q <= opnd;
    end else if (count != '0) begin
      count <= count - CW'(1);
      hi    <= hi_nxt;
      lo    <= lo_nxt;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: simple ops in 1 cycle, mul/div in DATA_WIDTH+1 cycles.
// Result is held in DONE until out_ready; flush/reset abort any op.
module alu_mc
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     busy
);
  localparam int W  = DATA_WIDTH;
  localparam int SW = $clog2(DATA_WIDTH);
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

  state_e        state, state_nxt;
  logic [4:0]    op, op_q;
  logic          neg_q, neg_d, accept, start, load_res, core_done;
  logic          div_zero, div_ovf;
  logic [SW-1:0] shamt;
  logic [W-1:0]  a_mag, b_mag, core_hi, core_lo;
  logic [W-1:0]  simple_res, special_res, fixed_res, res_d;

  assign op    = Operation[4:0];
  assign shamt = SrcB[SW-1:0];

  always_comb begin
    simple_res = '0;
    case (op)
      OP_AND:  simple_res = SrcA & SrcB;
      OP_OR:   simple_res = SrcA | SrcB;
      OP_ADD:  simple_res = SrcA + SrcB;
      OP_SUB:  simple_res = SrcA - SrcB;
      OP_XOR:  simple_res = SrcA ^ SrcB;
      OP_SLL:  simple_res = SrcA << shamt;
      OP_SRA:  simple_res = W'($signed(SrcA) >>> shamt);
      OP_SLT:  simple_res = W'($signed(SrcA) < $signed(SrcB));
      OP_EQ:   simple_res = W'(SrcA == SrcB);
      OP_SRL:  simple_res = SrcA >> shamt;
      OP_SLTU: simple_res = W'(SrcA < SrcB);
      default: simple_res = '0;
    endcase
  end

  // Degenerate divides finish at accept instead of iterating.
  assign div_zero    = is_div_op(op) && (SrcB == '0);
  assign div_ovf     = is_div_op(op) && !op[0] && (SrcA == MIN) && (SrcB == '1);
  assign special_res = op[1] ? (div_zero ? SrcA : '0) : (div_zero ? '1 : MIN);

  assign a_mag = (is_signed_op(op) && SrcA[W-1]) ? -SrcA : SrcA;
  assign b_mag = (is_signed_op(op) && SrcB[W-1]) ? -SrcB : SrcB;
  assign neg_d = (op == OP_REM) ? SrcA[W-1]
               : (is_signed_op(op) && (SrcA[W-1] ^ SrcB[W-1]));

  alu_muldiv_iter #(.W(W)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .is_div (op[2]),
    .a      (a_mag),
    .b      (b_mag),
    .done   (core_done),
    .hi     (core_hi),
    .lo     (core_lo)
  );

  // High half of the negated 2W product: ~hi plus the carry out of ~lo+1.
  always_comb begin
    fixed_res = '0;
    case (op_q)
      OP_MUL:           fixed_res = core_lo;
      OP_MULH:          fixed_res = neg_q ? (~core_hi + W'(core_lo == '0)) : core_hi;
      OP_MULHU:         fixed_res = core_hi;
      OP_DIV, OP_DIVU:  fixed_res = neg_q ? -core_lo : core_lo;
      OP_REM, OP_REMU:  fixed_res = neg_q ? -core_hi : core_hi;
      default:          fixed_res = '0;
    endcase
  end

  assign in_ready = !reset && !flush && ((state == IDLE) || (state == DONE && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    load_res  = 1'b0;
    res_d     = simple_res;
    case (state)
      ITER: if (core_done) begin
        state_nxt = DONE;
        load_res  = 1'b1;
        res_d     = fixed_res;
      end
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = state;
    endcase
    if (accept) begin
      if (is_muldiv(op) && !div_zero && !div_ovf) begin
        state_nxt = ITER;
        start     = 1'b1;
      end else begin
        state_nxt = DONE;
        load_res  = 1'b1;
        res_d     = (div_zero || div_ovf) ? special_res : simple_res;
      end
    end
    if (reset || flush) begin
      state_nxt = IDLE;
      start     = 1'b0;
      load_res  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      busy      <= 1'b0;
      ALUResult <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
    end else begin
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt == ITER);
      if (load_res) ALUResult <= res_d;
      if (start) begin
        op_q  <= op;
        neg_q <= neg_d;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed corner cases plus random ops against an arithmetic reference model.
module tb_alu_mc;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [31:0] SrcA, SrcB, ALUResult;
  logic [4:0]  Operation;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_exp;

  logic [4:0]  shift_ops [3] = '{OP_SLL, OP_SRA, OP_SRL};
  logic [31:0] shamts    [3] = '{32'd0, 32'd31, 32'd32};
  logic [4:0]  rnd_ops  [21] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR, OP_SLL, OP_SRA, OP_SLT,
                                 OP_EQ, OP_SRL, OP_SLTU, OP_MUL, OP_MULH, OP_MULHU, OP_DIV,
                                 OP_DIVU, OP_REM, OP_REMU, 5'b01011, 5'b10011, 5'b11111};

  always #5 clk = ~clk;

  alu_mc #(.DATA_WIDTH(32), .OPCODE_LENGTH(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Operation (Operation),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic [4:0]         sh;
    int                 sa, sb;
    sh = b[4:0];
    sa = a;
    sb = b;
    case (op)
      OP_AND:   return a & b;
      OP_OR:    return a | b;
      OP_ADD:   return a + b;
      OP_SUB:   return a - b;
      OP_XOR:   return a ^ b;
      OP_SLL:   return a << sh;
      OP_SRA:   return 32'($signed(a) >>> sh);
      OP_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
      OP_EQ:    return (a == b) ? 32'd1 : 32'd0;
      OP_SRL:   return a >> sh;
      OP_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      OP_MUL:   begin up = a * b; return up[31:0]; end
      OP_MULH:  begin sp = $signed(a) * $signed(b); return sp[63:32]; end
      OP_MULHU: begin up = a * b; return up[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return 32'(sa / sb);
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return 32'(sa % sb);
      end
      OP_DIVU:  return (b == 0) ? 32'hFFFFFFFF : a / b;
      OP_REMU:  return (b == 0) ? a : a % b;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_MUL, OP_MULH, OP_MULHU: return 33;
      OP_DIVU, OP_REMU:          return (b == 0) ? 1 : 33;
      OP_DIV, OP_REM:            return (b == 0 || (a == 32'h80000000 && b == 32'hFFFFFFFF)) ? 1 : 33;
      default:                   return 1;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; returns just after the accepting posedge.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    in_valid  = 1'b1;
    #1 chk("in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Returns at the negedge where out_valid is first seen.
  task automatic wait_result(input string tag, input logic [31:0] exp, input int exp_lat);
    int   lat = 0;
    logic bsy = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      bsy |= busy;
    end while (!out_valid && lat < 100);
    chk({tag, "/lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/busy"}, {31'b0, bsy}, (exp_lat > 1) ? 32'd1 : 32'd0);
    if (out_valid) chk({tag, "/res"}, ALUResult, exp);
    last_exp = exp;
  endtask

  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    issue(op, a, b);
    wait_result(tag, exp, exp_lat);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    Operation = '0; SrcA = '0; SrcB = '0; last_exp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst/out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst/result", ALUResult, 32'd0);
    chk("rst/busy", {31'b0, busy}, 32'd0);
    chk("rst/in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);

    run_op("add", OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1);
    run_op("xor_b2b", OP_XOR, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 1);

    run_op("mul", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
    run_op("mulh", OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    run_op("mulhu", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulh_min", OP_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 33);

    run_op("div_m7", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run_op("rem_m7", OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    run_op("divu_z", OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_op("remu_z", OP_REMU, 32'd5, 32'd0, 32'd5, 1);

    run_op("bp_mul", OP_MUL, 32'h12345678, 32'd9, 32'hA3D70A38, 33);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp/out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp/result", ALUResult, 32'hA3D70A38);
      chk("bp/in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp/drained", {31'b0, out_valid}, 32'd0);

    issue(OP_DIVU, 32'd1000, 32'd7);
    repeat (12) @(negedge clk);
    chk("fl/busy_before", {31'b0, busy}, 32'd1);
    flush = 1'b1; Operation = OP_ADD; SrcA = 32'd1; SrcB = 32'd1; in_valid = 1'b1;
    #1 chk("fl/in_ready_during", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("fl/out_valid", {31'b0, out_valid}, 32'd0);
    chk("fl/busy", {31'b0, busy}, 32'd0);
    chk("fl/in_ready", {31'b0, in_ready}, 32'd1);
    chk("fl/result_kept", ALUResult, last_exp);
    @(negedge clk);
    chk("fl/out_valid2", {31'b0, out_valid}, 32'd0);
    run_op("fl_next", OP_DIVU, 32'd1000, 32'd7, 32'd142, 33);

    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rm/out_valid", {31'b0, out_valid}, 32'd0);
    chk("rm/result", ALUResult, 32'd0);
    chk("rm/in_ready", {31'b0, in_ready}, 32'd1);
    chk("rm/busy", {31'b0, busy}, 32'd0);

    run_op("sll32", OP_SLL, 32'h800000F1, 32'd32, 32'h800000F1, 1);
    run_op("sra31", OP_SRA, 32'h800000F1, 32'd31, 32'hFFFFFFFF, 1);
    foreach (shift_ops[i]) begin
      foreach (shamts[j]) begin
        run_op($sformatf("shift_op%b_sh%0d", shift_ops[i], shamts[j]), shift_ops[i],
               32'h800000F1, shamts[j], ref_res(shift_ops[i], 32'h800000F1, shamts[j]), 1);
      end
    end

    for (int k = 0; k < 80; k++) begin
      logic [4:0]  o;
      logic [31:0] a, b;
      o = rnd_ops[$urandom_range(0, 20)];
      a = pick();
      b = pick();
      run_op($sformatf("rnd%0d_op%b_%h_%h", k, o, a, b), o, a, b, ref_res(o, a, b), ref_lat(o, a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
